pwm_ramp_ctrl: RTL and testbench

//   Soft-start/soft-stop sequencer for one pwm generator instance. It accepts a

---
 rtl/pwm_ramp_ctrl.sv | 158 +++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for one PWM generator: ramps duty toward a
// target by a bounded step per PWM period and gates the generator enable.
module pwm_ramp_ctrl #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WIDTH-1:0]  cfg_period,
    input  logic [WIDTH-1:0]  cfg_duty,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic              stop,
    input  logic              pwm_tick,
    output logic              pwm_enable,
    output logic [WIDTH-1:0]  pwm_period,
    output logic [WIDTH-1:0]  pwm_duty,
    output logic              ramping,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        HOLD,
        STOPPING
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   target;
    logic [STEP_W-1:0]  step;
    logic [WIDTH-1:0]   sh_period;
    logic [WIDTH-1:0]   sh_target;
    logic [STEP_W-1:0]  sh_step;
    logic               pend;

    logic               accept;
    logic               advance;
    logic [WIDTH-1:0]   clamp;
    logic [WIDTH-1:0]   use_target;
    logic [STEP_W-1:0]  use_step;
    logic [WIDTH-1:0]   nxt_duty;
    logic [WIDTH-1:0]   down_duty;

    // One extra bit keeps duty+step and duty-step exact before saturation.
    function automatic logic [WIDTH-1:0] toward(
        input logic [WIDTH-1:0]  cur,
        input logic [WIDTH-1:0]  tgt,
        input logic [STEP_W-1:0] stp
    );
        logic [WIDTH:0] wide;
        logic [WIDTH:0] s;
        s      = (WIDTH+1)'(stp);
        wide   = '0;
        toward = tgt;
        if (stp != '0) begin
            if (cur < tgt) begin
                wide = {1'b0, cur} + s;
                if (wide < {1'b0, tgt})
                    toward = wide[WIDTH-1:0];
            end else begin
                wide = {1'b0, cur} - s;
                if (!wide[WIDTH] && wide[WIDTH-1:0] > tgt)
                    toward = wide[WIDTH-1:0];
            end
        end
    endfunction

    assign cfg_ready  = (state != STOPPING) && !stop;
    assign accept     = cfg_valid && cfg_ready;
    assign clamp      = (cfg_duty > cfg_period) ? cfg_period : cfg_duty;
    assign use_target = pend ? sh_target : target;
    assign use_step   = pend ? sh_step : step;
    assign nxt_duty   = toward(pwm_duty, use_target, use_step);
    assign down_duty  = toward(pwm_duty, '0, step);
    assign advance    = pwm_tick && (pend || state == RAMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pwm_enable <= 1'b0;
            pwm_period <= '0;
            pwm_duty   <= '0;
            ramping    <= 1'b0;
            done       <= 1'b0;
            target     <= '0;
            step       <= '0;
            sh_period  <= '0;
            sh_target  <= '0;
            sh_step    <= '0;
            pend       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        pwm_period <= cfg_period;
                        target     <= clamp;
                        step       <= cfg_step;
                        pwm_enable <= 1'b1;
                        pwm_duty   <= '0;
                        ramping    <= 1'b1;
                        state      <= RAMP;
                    end
                end
                RAMP, HOLD: begin
                    if (stop) begin
                        target  <= '0;
                        pend    <= 1'b0;
                        ramping <= 1'b1;
                        state   <= STOPPING;
                    end else begin
                        if (advance) begin
                            if (pend) begin
                                pwm_period <= sh_period;
                                target     <= sh_target;
                                step       <= sh_step;
                                pend       <= 1'b0;
                            end
                            pwm_duty <= nxt_duty;
                            if (nxt_duty == use_target) begin
                                state   <= HOLD;
                                ramping <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                state   <= RAMP;
                                ramping <= 1'b1;
                            end
                        end
                        // A tick in this same cycle already consumed the old values.
                        if (accept) begin
                            sh_period <= cfg_period;
                            sh_target <= clamp;
                            sh_step   <= cfg_step;
                            pend      <= 1'b1;
                            state     <= RAMP;
                            ramping   <= 1'b1;
                            done      <= 1'b0;
                        end
                    end
                end
                STOPPING: begin
                    if (pwm_tick) begin
                        pwm_duty <= down_duty;
                        if (down_duty == '0) begin
                            pwm_enable <= 1'b0;
                            ramping    <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed spec scenarios plus randomized traffic, checked against an
// integer-arithmetic reference model of the ramp sequencer.
module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [15:0] cfg_duty;
    logic [7:0]  cfg_step;
    logic        stop;
    logic        pwm_tick;
    logic        pwm_enable;
    logic [15:0] pwm_period;
    logic [15:0] pwm_duty;
    logic        ramping;
    logic        done;

    int checks = 0;
    int errors = 0;

    pwm_ramp_ctrl #(.WIDTH(16), .STEP_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_step   (cfg_step),
        .stop       (stop),
        .pwm_tick   (pwm_tick),
        .pwm_enable (pwm_enable),
        .pwm_period (pwm_period),
        .pwm_duty   (pwm_duty),
        .ramping    (ramping),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 ramping up/down, 2 holding, 3 stopping
    int m_mode, m_en, m_per, m_duty, m_tgt, m_step, m_done;
    int p_on, p_per, p_tgt, p_step;

    function automatic int approach(int cur, int tgt, int stp);
        if (stp == 0) return tgt;
        if (cur < tgt) return (cur + stp > tgt) ? tgt : cur + stp;
        return (cur - stp < tgt) ? tgt : cur - stp;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_en = 0; m_per = 0; m_duty = 0;
        m_tgt = 0; m_step = 0; m_done = 0;
        p_on = 0; p_per = 0; p_tgt = 0; p_step = 0;
    endtask

    function automatic int model_ready(int s);
        return (m_mode != 3 && s == 0) ? 1 : 0;
    endfunction

    task automatic model_edge(int v, int per, int duty, int stp, int s, int tk);
        int acc;
        int lim;
        acc = v && model_ready(s);
        lim = (duty < per) ? duty : per;
        m_done = 0;
        if (m_mode == 0) begin
            if (acc) begin
                m_per = per; m_tgt = lim; m_step = stp;
                m_en = 1; m_duty = 0; m_mode = 1;
            end
        end else if (m_mode == 3) begin
            if (tk) begin
                m_duty = approach(m_duty, 0, m_step);
                if (m_duty == 0) begin m_en = 0; m_mode = 0; end
            end
        end else if (s) begin
            m_mode = 3; m_tgt = 0; p_on = 0;
        end else begin
            if (tk && (p_on || m_mode == 1)) begin
                if (p_on) begin
                    m_per = p_per; m_tgt = p_tgt; m_step = p_step; p_on = 0;
                end
                m_duty = approach(m_duty, m_tgt, m_step);
                if (m_duty == m_tgt) begin m_mode = 2; m_done = 1; end
                else m_mode = 1;
            end
            if (acc) begin
                p_per = per; p_tgt = lim; p_step = stp; p_on = 1;
                m_mode = 1; m_done = 0;
            end
        end
    endtask

    task automatic chk(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_model();
        chk("enable", int'(pwm_enable), m_en);
        chk("period", int'(pwm_period), m_per);
        chk("duty",   int'(pwm_duty),   m_duty);
        chk("ramping", int'(ramping), (m_mode == 1 || m_mode == 3) ? 1 : 0);
        chk("done",   int'(done),       m_done);
    endtask

    // One clock: drive inputs, check cfg_ready, clock, check outputs, idle inputs.
    task automatic cyc(int v, int per, int duty, int stp, int s, int tk);
        cfg_valid  = 1'(v);
        cfg_period = 16'(per);
        cfg_duty   = 16'(duty);
        cfg_step   = 8'(stp);
        stop       = 1'(s);
        pwm_tick   = 1'(tk);
        #1;
        chk("cfg_ready", int'(cfg_ready), model_ready(s));
        @(posedge clk);
        model_edge(v, per, duty, stp, s, tk);
        #1;
        chk_model();
        cfg_valid = 1'b0;
        stop      = 1'b0;
        pwm_tick  = 1'b0;
    endtask

    task automatic tick_once();
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0;
        cfg_step = '0; stop = 1'b0; pwm_tick = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(cfg_ready), 1);
        chk_model();
        rst_n = 1'b1;

        // Soft start 0 -> 40 in steps of 10
        cyc(1, 100, 40, 10, 0, 0);
        chk("t1_enable", int'(pwm_enable), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 1);
            chk("t1_duty", int'(pwm_duty), 10 * (i + 1));
            chk("t1_done", int'(done), (i == 3) ? 1 : 0);
            cyc(0, 0, 0, 0, 0, 0);
        end

        // Ramp down with saturation at 15
        cyc(1, 100, 15, 10, 0, 0);
        tick_once();
        chk("t2_duty30", int'(pwm_duty), 30);
        tick_once();
        chk("t2_duty20", int'(pwm_duty), 20);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t2_duty15", int'(pwm_duty), 15);
        chk("t2_done", int'(done), 1);
        cyc(0, 0, 0, 0, 0, 0);

        // Clamp to period, step 0 jumps
        cyc(1, 200, 250, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t3_duty", int'(pwm_duty), 200);
        chk("t3_period", int'(pwm_period), 200);

        // Hold at 30 with step 20, then stop
        cyc(1, 100, 30, 0, 0, 0);
        tick_once();
        cyc(1, 100, 30, 20, 0, 0);
        tick_once();
        cyc(0, 0, 0, 0, 1, 0);
        tick_once();
        chk("t4_duty10", int'(pwm_duty), 10);
        tick_once();
        chk("t4_duty0", int'(pwm_duty), 0);
        chk("t4_enable", int'(pwm_enable), 0);
        chk("t4_ready", int'(cfg_ready), 1);

        // Accept coinciding with a tick takes effect at the following tick
        cyc(1, 100, 40, 0, 0, 0);
        tick_once();
        cyc(1, 50, 20, 0, 0, 1);
        chk("t5_period_old", int'(pwm_period), 100);
        tick_once();
        chk("t5_period_new", int'(pwm_period), 50);
        chk("t5_duty", int'(pwm_duty), 20);

        // Near full scale: no wrap, then async reset mid-ramp
        cyc(1, 16'hFFFF, 16'hFFF0, 0, 0, 0);
        tick_once();
        cyc(1, 16'hFFFF, 16'hFFFF, 8'hFF, 0, 0);
        tick_once();
        chk("t6_sat", int'(pwm_duty), 16'hFFFF);
        cyc(1, 16'hFFFF, 0, 1, 0, 0);
        tick_once();
        tick_once();
        chk("t6_down", int'(pwm_duty), 16'hFFFD);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_enable", int'(pwm_enable), 0);
        chk("t6_rst_duty", int'(pwm_duty), 0);
        chk("t6_rst_period", int'(pwm_period), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(99) < 30) ? 1 : 0,
                int'($urandom_range(300)),
                int'($urandom_range(350)),
                int'($urandom_range(40)),
                ($urandom_range(99) < 4) ? 1 : 0,
                ($urandom_range(99) < 25) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
